run_ctrl: RTL

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 32 +++
 rtl/run_chk.sv | 59 +++++
 rtl/run_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding, default parameter values and state
// decode helpers for the run controller and its result checker.
package run_ctrl_pkg;

  localparam int unsigned AW_DEF        = 8;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned CW_DEF        = 16;
  localparam int unsigned START_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_RUN    = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // A run is in progress from the memory clear through the result check.
  function automatic logic state_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_LAUNCH) ||
           (s == ST_RUN)   || (s == ST_CHECK);
  endfunction

  // The core is held in start/reset until it is released into RUN.
  function automatic logic state_hold_core(input state_e s);
    return (s == ST_IDLE) || (s == ST_CLEAR) || (s == ST_LOAD) ||
           (s == ST_LAUNCH);
  endfunction

endpackage

// File: rtl/run_chk.sv
// run_chk: result comparator. A read issued in cycle t returns mem_rdata in
// cycle t+1; the expected word is captured with the issue so both sides of
// the compare line up. Mismatches bump a saturating error counter.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   clr                  zero the error counter (start of a new run)
//   issue                a check read is addressed this cycle
//   exp_data             expected value for the word addressed this cycle
//   mem_rdata            memory read data (one cycle after the address)
//   err_cnt              registered mismatch count
//   err_next_c           mismatch count including this cycle's compare
module run_chk
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          issue,
  input  logic [DW-1:0] exp_data,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] err_cnt,
  output logic [AW-1:0] err_next_c
);

  localparam logic [AW-1:0] ERR_MAX = '1;

  logic          vld_q, vld_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [AW-1:0] err_q, err_d;

  // Compare the returning word against the expectation captured at issue.
  always_comb begin
    vld_d      = issue;
    exp_d      = issue ? exp_data : exp_q;
    err_next_c = err_q;
    if (vld_q && (mem_rdata != exp_q) && (err_q != ERR_MAX)) begin
      err_next_c = err_q + AW'(1);
    end
    err_d = clr ? '0 : err_next_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      exp_q <= '0;
      err_q <= '0;
    end else begin
      vld_q <= vld_d;
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: test-run sequencer. On go it clears the data memory, streams a
// preload image into it, releases the core, waits for halt (or a cycle
// limit), then checks a window of result words against expected values.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   go                                start a run (IDLE/DONE only)
//   mem_we/mem_addr/mem_wdata         data-memory write/address port
//   mem_rdata                         data-memory read data, 1-cycle latency
//   ld_valid/ld_addr/ld_data/ld_last  preload word stream, ld_ready handshake
//   core_start                        holds the core in start while high
//   core_halt                         core finished
//   chk_base/chk_len                  result window start and length
//   exp_idx/exp_data                  index of / expected value for checked word
//   timeout_lim                       RUN cycle limit
//   busy/done/pass/timeout            status; done/pass/timeout held to next go
//   err_cnt/cycle_cnt                 mismatch count, RUN cycle count
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned CW        = CW_DEF,
  parameter int unsigned START_CYC = START_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          core_start,
  input  logic          core_halt,
  input  logic [AW-1:0] chk_base,
  input  logic [AW-1:0] chk_len,
  output logic [AW-1:0] exp_idx,
  input  logic [DW-1:0] exp_data,
  input  logic [CW-1:0] timeout_lim,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [AW-1:0] err_cnt,
  output logic [CW-1:0] cycle_cnt
);

  localparam int unsigned   LW       = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [LW-1:0] LC_LAST  = LW'(START_CYC - 1);
  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [CW-1:0] CYC_MAX  = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;   // clear address in CLEAR, check index in CHECK
  logic [LW-1:0] lc_q, lc_d;       // LAUNCH cycle counter
  logic [CW-1:0] cyc_q, cyc_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          to_q, to_d;

  logic          clr_c;
  logic          issue_c;
  logic [AW-1:0] err_next_c;
  logic [CW-1:0] cyc_inc_c;

  run_chk #(
    .AW (AW),
    .DW (DW)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_c),
    .issue      (issue_c),
    .exp_data   (exp_data),
    .mem_rdata  (mem_rdata),
    .err_cnt    (err_cnt),
    .err_next_c (err_next_c)
  );

  // Count including the current RUN cycle; saturates at all-ones.
  assign cyc_inc_c = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CW'(1);

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    lc_d       = lc_q;
    cyc_d      = cyc_q;
    done_d     = done_q;
    pass_d     = pass_q;
    to_d       = to_q;
    clr_c      = 1'b0;
    issue_c    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = '0;
    ld_ready   = 1'b0;
    exp_idx    = addr_q;
    busy       = state_busy(state_q);
    core_start = state_hold_core(state_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          cyc_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          to_d    = 1'b0;
          clr_c   = 1'b1;
        end
      end

      ST_CLEAR: begin
        mem_we = 1'b1;
        addr_d = addr_q + AW'(1);
        if (addr_q == ADDR_MAX) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          if (ld_last) begin
            state_d = ST_LAUNCH;
            lc_d    = '0;
          end
        end
      end

      ST_LAUNCH: begin
        lc_d = lc_q + LW'(1);
        if (lc_q == LC_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cyc_d = cyc_inc_c;
        // Halt takes priority over a limit reached in the same cycle.
        if (core_halt) begin
          state_d = ST_CHECK;
          addr_d  = '0;
        end else if (cyc_inc_c == timeout_lim) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end
      end

      ST_CHECK: begin
        mem_addr = chk_base + addr_q;
        // The final cycle issues nothing; it only retires the last compare.
        if (addr_q == chk_len) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_next_c == '0);
          to_d    = 1'b0;
        end else begin
          issue_c = 1'b1;
          addr_d  = addr_q + AW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      lc_q    <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lc_q    <= lc_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = to_q;
  assign cycle_cnt = cyc_q;

endmodule
